mdu_ctrl: RTL and testbench

MDU_CTRL -- requirements
Module: mdu_ctrl

---
 rtl/mdu_pkg.sv | 23 ++
 rtl/mdu_ctrl_if.sv | 31 +++
 rtl/mdu_step.sv | 32 +++
 rtl/mdu_ctrl.sv | 123 ++++++++++++
 tb/tb_mdu_ctrl.sv | 159 +++++++++++++++
 5 files changed

// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit.
//   op_e    : operation encoding carried on the op field of the request
//   state_t : sequencer state encoding
//   MDU_ITER: iterations per operation (one result bit per cycle)
package mdu_pkg;

   localparam int MDU_ITER = 32;

   typedef enum logic [1:0] {
      OP_MULTU = 2'b00,
      OP_MUL   = 2'b01,
      OP_DIV   = 2'b10,
      OP_DIVU  = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_CALC = 2'b01,
      S_FIX  = 2'b10,
      S_DONE = 2'b11
   } state_t;

endpackage

// File: rtl/mdu_ctrl_if.sv
// Request/result bundle between the decode stage and the MDU.
//   master: issues start/op/a/b/cancel, observes stall and results
//   slave : the MDU side
interface mdu_ctrl_if;
   import mdu_pkg::*;

   logic        start;
   op_e         op;
   logic [31:0] a;
   logic [31:0] b;
   logic        cancel;
   logic        stall;
   logic        done;
   logic [31:0] hi;
   logic [31:0] lo;
   logic        hi_we;
   logic        lo_we;
   logic        rf_we;
   logic        dz;

   modport master (
      output start, op, a, b, cancel,
      input  stall, done, hi, lo, hi_we, lo_we, rf_we, dz
   );

   modport slave (
      input  start, op, a, b, cancel,
      output stall, done, hi, lo, hi_we, lo_we, rf_we, dz
   );

endinterface

// File: rtl/mdu_step.sv
// One combinational iteration of the MDU datapath.
//   is_div : 1 = restoring divide step, 0 = shift-add multiply step
//   acc    : 64-bit accumulator {hi, lo}
//   d      : multiplicand (multiply) or divisor (divide) magnitude
//   acc_nxt: accumulator after this iteration
module mdu_step (
   input  logic        is_div,
   input  logic [63:0] acc,
   input  logic [31:0] d,
   output logic [63:0] acc_nxt
);

   logic [32:0] sum;
   logic [32:0] diff;

   // Multiply: lo holds the remaining multiplier bits; add on lsb, shift right
   // with the carry entering at the top.
   assign sum  = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, d} : 33'd0);

   // Divide: trial-subtract the divisor from the left-shifted remainder.
   // Bit 32 of the difference is the borrow (trial < divisor).
   assign diff = acc[63:31] - {1'b0, d};

   always_comb begin
      acc_nxt = {sum, acc[31:1]};
      if (is_div) begin
         if (diff[32]) acc_nxt = {acc[62:0], 1'b0};
         else          acc_nxt = {diff[31:0], acc[30:0], 1'b1};
      end
   end

endmodule

// File: rtl/mdu_ctrl.sv
// Iterative multiply/divide unit: MULTU, MUL, DIV, DIVU.
// Accept cycle 0, 32 iteration cycles, one sign fix-up cycle, result in
// cycle 34 with single-cycle strobes.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : request (start/op/a/b/cancel) and result
//                (stall/done/hi/lo/hi_we/lo_we/rf_we/dz)
module mdu_ctrl
   import mdu_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   mdu_ctrl_if.slave   bus
);

   state_t      state;
   logic [5:0]  cnt;
   logic [63:0] acc;
   logic [63:0] acc_nxt;
   logic [31:0] d_q;
   op_e         op_q;
   logic        sgn_a, sgn_b;
   logic [31:0] hi_q, lo_q;
   logic        done_q, dz_q, hilo_q, rf_q;

   // Operand conditioning at accept
   logic        in_signed, in_div, in_sa, in_sb;
   logic [31:0] mag_a, mag_b;

   assign in_signed = (bus.op == OP_MUL) || (bus.op == OP_DIV);
   assign in_div    = (bus.op == OP_DIV) || (bus.op == OP_DIVU);
   assign in_sa     = in_signed & bus.a[31];
   assign in_sb     = in_signed & bus.b[31];
   assign mag_a     = in_sa ? -bus.a : bus.a;
   assign mag_b     = in_sb ? -bus.b : bus.b;

   logic is_div;
   assign is_div = (op_q == OP_DIV) || (op_q == OP_DIVU);

   mdu_step u_step (
      .is_div  (is_div),
      .acc     (acc),
      .d       (d_q),
      .acc_nxt (acc_nxt)
   );

   // Sign fix-up of the raw magnitude result
   logic [63:0] prod;
   logic [31:0] quo, rem;
   logic        div_zero;

   assign div_zero = is_div && (d_q == 32'd0);
   assign prod     = (sgn_a ^ sgn_b) ? -acc : acc;
   assign quo      = div_zero ? 32'hFFFF_FFFF
                   : ((sgn_a ^ sgn_b) ? -acc[31:0] : acc[31:0]);
   // With a zero divisor the remainder magnitude equals |a|, so restoring
   // the dividend sign yields hi = a for both DIV and DIVU.
   assign rem      = sgn_a ? -acc[63:32] : acc[63:32];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state  <= S_IDLE;
         cnt    <= '0;
         acc    <= '0;
         d_q    <= '0;
         op_q   <= OP_MULTU;
         sgn_a  <= 1'b0;
         sgn_b  <= 1'b0;
         hi_q   <= '0;
         lo_q   <= '0;
         done_q <= 1'b0;
         dz_q   <= 1'b0;
         hilo_q <= 1'b0;
         rf_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (bus.cancel) begin
            state <= S_IDLE;
            cnt   <= '0;
         end else begin
            case (state)
               S_IDLE: if (bus.start) begin
                  op_q  <= bus.op;
                  sgn_a <= in_sa;
                  sgn_b <= in_sb;
                  // Divide: dividend in lo, divisor in d. Multiply: multiplier
                  // in lo, multiplicand in d.
                  acc   <= {32'd0, in_div ? mag_a : mag_b};
                  d_q   <= in_div ? mag_b : mag_a;
                  cnt   <= '0;
                  state <= S_CALC;
               end
               S_CALC: begin
                  acc <= acc_nxt;
                  cnt <= cnt + 6'd1;
                  if (cnt == 6'(MDU_ITER - 1)) state <= S_FIX;
               end
               S_FIX: begin
                  hi_q   <= is_div ? rem : prod[63:32];
                  lo_q   <= is_div ? quo : prod[31:0];
                  dz_q   <= div_zero;
                  hilo_q <= (op_q != OP_MUL);
                  rf_q   <= (op_q == OP_MUL);
                  done_q <= 1'b1;
                  state  <= S_DONE;
               end
               default: state <= S_IDLE;
            endcase
         end
      end
   end

   // A cancel landing on the result cycle kills every strobe.
   assign bus.done  = done_q & ~bus.cancel;
   assign bus.hi_we = done_q & hilo_q & ~bus.cancel;
   assign bus.lo_we = done_q & hilo_q & ~bus.cancel;
   assign bus.rf_we = done_q & rf_q & ~bus.cancel;
   assign bus.dz    = done_q & dz_q & ~bus.cancel;
   assign bus.hi    = hi_q;
   assign bus.lo    = lo_q;
   assign bus.stall = rst_n & (((state == S_IDLE) & bus.start) |
                               (state == S_CALC) | (state == S_FIX));

endmodule

// File: tb/tb_mdu_ctrl.sv
module tb_mdu_ctrl;
   import mdu_pkg::*;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   mdu_ctrl_if bus ();

   mdu_ctrl dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   typedef struct {
      logic [31:0] hi;
      logic [31:0] lo;
      logic        hi_we;
      logic        lo_we;
      logic        rf_we;
      logic        dz;
   } exp_t;

   exp_t sb_q[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: plain wide arithmetic
   function automatic exp_t model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
      exp_t        e;
      logic [63:0] up;
      longint      sa, sbv, p, q, r;
      e.hi_we = 1'b1; e.lo_we = 1'b1; e.rf_we = 1'b0; e.dz = 1'b0;
      sa  = longint'($signed(a));
      sbv = longint'($signed(b));
      case (o)
         2'b00: begin up = {32'd0, a} * {32'd0, b}; e.hi = up[63:32]; e.lo = up[31:0]; end
         2'b01: begin
            p = sa * sbv; e.hi = p[63:32]; e.lo = p[31:0];
            e.hi_we = 1'b0; e.lo_we = 1'b0; e.rf_we = 1'b1;
         end
         default: begin
            if (b == 32'd0) begin
               e.hi = a; e.lo = 32'hFFFF_FFFF; e.dz = 1'b1;
            end else if (o == 2'b10) begin
               q = sa / sbv; r = sa % sbv; e.hi = r[31:0]; e.lo = q[31:0];
            end else begin
               e.hi = a % b; e.lo = a / b;
            end
         end
      endcase
      return e;
   endfunction

   // Result monitor / scoreboard
   always @(negedge clk) begin
      if (bus.done === 1'b1) begin
         if (sb_q.size() == 0) chk("spurious_done", {63'd0, bus.done}, 64'd0);
         else begin
            exp_t e;
            e = sb_q.pop_front();
            chk("hi", {32'd0, bus.hi}, {32'd0, e.hi});
            chk("lo", {32'd0, bus.lo}, {32'd0, e.lo});
            chk("strobes", {60'd0, bus.hi_we, bus.lo_we, bus.rf_we, bus.dz},
                           {60'd0, e.hi_we, e.lo_we, e.rf_we, e.dz});
         end
      end else if ((bus.hi_we | bus.lo_we | bus.rf_we | bus.dz) === 1'b1) begin
         chk("strobe_no_done", {60'd0, bus.hi_we, bus.lo_we, bus.rf_we, bus.dz}, 64'd0);
      end
   end

   // Issue one operation; optional cancel / reset / stray start at a cycle
   // index (cycle 0 = accept). Only clean operations are scoreboarded.
   task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input int cancel_at, input int rst_at, input int start_at);
      bit normal;
      bit stall_ok;
      int lat;
      normal   = (cancel_at < 0) && (rst_at < 0);
      stall_ok = 1'b1;
      lat      = 0;
      @(posedge clk); #1;
      bus.start = 1'b1; bus.op = op_e'(o); bus.a = a; bus.b = b;
      if (normal) sb_q.push_back(model(o, a, b));
      @(negedge clk);
      stall_ok &= (bus.stall === 1'b1);
      for (int cyc = 1; cyc <= 45; cyc++) begin
         @(posedge clk); #1;
         bus.start  = (cyc == start_at);
         bus.cancel = (cyc == cancel_at);
         rst_n      = !(cyc == rst_at);
         if (cyc == start_at) begin
            bus.op = OP_DIVU; bus.a = $urandom; bus.b = $urandom;
         end
         @(negedge clk);
         if (bus.done === 1'b1 && lat == 0) lat = cyc;
         if (normal && cyc <= 33) stall_ok &= (bus.stall === 1'b1);
         if (normal && cyc == 34) chk("stall_in_done", {63'd0, bus.stall}, 64'd0);
         if (cancel_at >= 0 && cyc == cancel_at + 1)
            chk("cancel_idle_stall", {63'd0, bus.stall}, 64'd0);
         if (rst_at >= 0 && cyc == rst_at)
            chk("rst_stall", {63'd0, bus.stall}, 64'd0);
         if (rst_at >= 0 && cyc == rst_at + 1)
            chk("rst_outputs", {bus.hi, bus.lo}, 64'd0);
      end
      bus.start = 1'b0; bus.cancel = 1'b0; rst_n = 1'b1;
      if (normal) begin
         chk("latency", 64'(lat), 64'd34);
         chk("stall_hold", {63'd0, stall_ok}, 64'd1);
      end
   endtask

   initial begin
      rst_n = 1'b0;
      bus.start = 1'b0; bus.op = OP_MULTU; bus.a = '0; bus.b = '0; bus.cancel = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset_stall", {63'd0, bus.stall}, 64'd0);
      chk("reset_hilo", {bus.hi, bus.lo}, 64'd0);
      chk("reset_strobes", {59'd0, bus.done, bus.hi_we, bus.lo_we, bus.rf_we, bus.dz}, 64'd0);
      @(posedge clk); #1; rst_n = 1'b1;

      run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, -1, -1);
      run_op(2'b01, 32'hFFFF_FFFD, 32'd7,         -1, -1,  5);  // stray start ignored
      run_op(2'b10, 32'hFFFF_FFF9, 32'd2,         -1, -1, -1);
      run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, -1, -1, -1);
      run_op(2'b11, 32'd5,         32'd0,         -1, -1, -1);
      run_op(2'b10, 32'hFFFF_FFF7, 32'd0,         -1, -1, -1);
      run_op(2'b11, 32'd100,       32'd7,         10, -1, -1);  // cancelled
      run_op(2'b11, 32'd100,       32'd7,         -1, -1, -1);
      run_op(2'b10, 32'd1234,      32'd9,         34, -1, -1);  // cancel in DONE
      run_op(2'b00, 32'h1234_5678, 32'h9ABC_DEF0, -1, 20, -1);  // reset mid-op

      // start together with cancel in IDLE: nothing accepted
      @(posedge clk); #1; bus.start = 1'b1; bus.cancel = 1'b1; bus.op = OP_MULTU;
      @(posedge clk); #1; bus.start = 1'b0; bus.cancel = 1'b0;
      @(negedge clk);
      chk("cancel_start_idle", {63'd0, bus.stall}, 64'd0);
      repeat (40) @(posedge clk);

      for (int i = 0; i < 6; i++)
         run_op(2'(i), $urandom, (i == 5) ? 32'd3 : $urandom, -1, -1, -1);

      repeat (5) @(posedge clk);
      chk("sb_empty", 64'(sb_q.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
